// File: rtl/apb_gpio_blink.sv
// APB3 GPIO slave: data/direction, synchronised input, rising-edge IRQ,
// and a blink engine that gates selected output bits.
module apb_gpio_blink #(
  parameter int GPIO_W   = 16,
  parameter int PERIOD_W = 24
) (
  input  logic              iHCLK,
  input  logic              iHRESETn,
  input  logic              iPSEL,
  input  logic              iPENABLE,
  input  logic              iPWRITE,
  input  logic [31:0]       iPADDR,
  input  logic [31:0]       iPWDATA,
  output logic [31:0]       oPRDATA,
  input  logic [GPIO_W-1:0] iGPIO_IN,
  output logic [GPIO_W-1:0] oGPIO_OUT,
  output logic [GPIO_W-1:0] oGPIO_OE,
  output logic              oIRQ
);

  localparam logic [2:0] A_DOUT   = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_DIN    = 3'd2;
  localparam logic [2:0] A_BLINK  = 3'd3;
  localparam logic [2:0] A_PERIOD = 3'd4;
  localparam logic [2:0] A_EDGE   = 3'd5;
  localparam logic [2:0] A_IRQEN  = 3'd6;

  logic              wr, rd;
  logic [2:0]        addr;
  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] rise, w1c;

  logic [GPIO_W-1:0]   dout_q, dout_d;
  logic [GPIO_W-1:0]   dir_q, dir_d;
  logic [GPIO_W-1:0]   blink_q, blink_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [GPIO_W-1:0]   edge_q, edge_d;
  logic [GPIO_W-1:0]   irq_en_q, irq_en_d;
  logic [GPIO_W-1:0]   sync1_q, sync2_q, sync3_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [31:0]         prdata_q, prdata_d;

  assign wr    = iPSEL & iPENABLE & iPWRITE;
  assign rd    = iPSEL & ~iPENABLE & ~iPWRITE;
  assign addr  = iPADDR[4:2];
  assign wdata = iPWDATA[GPIO_W-1:0];
  assign rise  = sync2_q & ~sync3_q;
  assign w1c   = (wr && addr == A_EDGE) ? wdata : '0;

  always_comb begin
    dout_d   = dout_q;
    dir_d    = dir_q;
    blink_d  = blink_q;
    period_d = period_q;
    irq_en_d = irq_en_q;
    if (wr) begin
      case (addr)
        A_DOUT:   dout_d   = wdata;
        A_DIR:    dir_d    = wdata;
        A_BLINK:  blink_d  = wdata;
        A_PERIOD: period_d = iPWDATA[PERIOD_W-1:0];
        A_IRQEN:  irq_en_d = wdata;
        default:  ;
      endcase
    end
  end

  // Set wins over a same-cycle clear so no edge is lost.
  assign edge_d = (edge_q & ~w1c) | rise;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr && addr == A_PERIOD) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + PERIOD_W'(1);
    end
  end

  always_comb begin
    prdata_d = prdata_q;
    if (rd) begin
      case (addr)
        A_DOUT:   prdata_d = 32'(dout_q);
        A_DIR:    prdata_d = 32'(dir_q);
        A_DIN:    prdata_d = 32'(sync2_q);
        A_BLINK:  prdata_d = 32'(blink_q);
        A_PERIOD: prdata_d = 32'(period_q);
        A_EDGE:   prdata_d = 32'(edge_q);
        A_IRQEN:  prdata_d = 32'(irq_en_q);
        default:  prdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge iHCLK or negedge iHRESETn) begin
    if (!iHRESETn) begin
      dout_q   <= '0;
      dir_q    <= '0;
      blink_q  <= '0;
      period_q <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      prdata_q <= '0;
    end else begin
      dout_q   <= dout_d;
      dir_q    <= dir_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      sync1_q  <= iGPIO_IN;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      prdata_q <= prdata_d;
    end
  end

  assign oPRDATA   = prdata_q;
  assign oGPIO_OE  = dir_q;
  assign oGPIO_OUT = dout_q & ~(blink_q & {GPIO_W{~phase_q}});
  assign oIRQ      = |(edge_q & irq_en_q);

endmodule

// File: doc/apb_gpio_blink.md
# apb_gpio_blink

APB3-style slave (no PREADY, no PSLVERR) for the LED/GPIO bank. It sits on either PSEL output of the AHB-to-APB bridge and has one instance per GPIO port. It provides:
- output data and direction registers;
- a synchronised input register;
- rising-edge capture with interrupt;
- a programmable blink engine that gates selected output bits.

All transfers complete with zero wait states: setup phase, then access phase.

## Interface
Parameters:
- GPIO_W, 16: number of GPIO pins (1..32).
- PERIOD_W, 24: width of the blink period counter/register (1..32).

Ports:
- iHCLK  in  1  system clock; APB runs on the AHB clock.
- iHRESETn  in  1  reset, asynchronous assert, active-low.
- iPSEL  in  1  slave select from the bridge.
- iPENABLE  in  1  access-phase strobe.
- iPWRITE  in  1  1 = write, 0 = read.
- iPADDR  in  32  byte address; only [4:2] is decoded.
- iPWDATA  in  32  write data.
- oPRDATA  out  32  read data, registered.
- iGPIO_IN  in  GPIO_W  asynchronous pin inputs.
- oGPIO_OUT  out  GPIO_W  pin output values.
- oGPIO_OE  out  GPIO_W  pin output enables (1 = drive).
- oIRQ  out  1  level interrupt.

## Operation
Register map (offset = iPADDR[4:2]×4). Unused upper bits read 0 and ignore writes.
- 0x00 DOUT (RW, GPIO_W): output data.
- 0x04 DIR (RW, GPIO_W): direction; drives oGPIO_OE directly.
- 0x08 DIN (RO): synchronised pin state (sync2). Writes are ignored.
- 0x0C BLINK_EN (RW, GPIO_W): per-bit blink gating.
- 0x10 PERIOD (RW, PERIOD_W): blink half-period minus 1.
- 0x14 EDGE (RW1C, GPIO_W): latched rising edges.
- 0x18 IRQ_EN (RW, GPIO_W): interrupt mask.
- 0x1C: reserved; reads 0, writes ignored.

Register write:
- Occurs on the edge where iPSEL & iPENABLE & iPWRITE.
- Writes are never taken in the setup phase.

Register read:
- oPRDATA is loaded on the edge where iPSEL & ~iPENABLE & ~iPWRITE (setup phase).
- It is therefore stable for the whole access phase.
- It holds its value until the next read setup phase; it is otherwise unchanged.

Input path:
- iGPIO_IN feeds a 2-flop synchroniser (sync1, sync2), followed by a third flop, sync3.
- rise = sync2 & ~sync3.
- Update rule: EDGE <= (EDGE & ~W1C_mask) | rise.
- W1C_mask is iPWDATA on a write to 0x14, else 0.
- A rise in the same cycle as a clear of that bit leaves the bit set (set wins).

Interrupt:
- oIRQ = |(EDGE & IRQ_EN), computed from flops only.
- It is glitch-free with respect to APB inputs.

Blink engine:
- Counter cnt (PERIOD_W bits) and phase flop.
- If PERIOD == 0: cnt is held at 0 and phase is forced to 1.
- Otherwise: when cnt == PERIOD, cnt <= 0 and phase toggles; else cnt <= cnt + 1.
- Any write to PERIOD clears cnt to 0 and phase to 0 on the same edge.
- oGPIO_OUT = DOUT & ~(BLINK_EN & {GPIO_W{~phase}}).
  - Blink bits output DOUT while phase = 1 and 0 while phase = 0.
  - Non-blink bits output DOUT.

Accesses with iPSEL = 0 have no effect. iPADDR above bit 4 is ignored; the bridge does the decode.

## Timing
Reset values (asynchronous, immediate on iHRESETn low):
- DOUT, DIR, BLINK_EN, PERIOD, EDGE, IRQ_EN = 0.
- sync1, sync2, sync3 = 0.
- cnt = 0; phase = 1 (because PERIOD = 0).
- oPRDATA = 0, oGPIO_OUT = 0, oGPIO_OE = 0, oIRQ = 0.

Reset mid-transfer:
- The transfer is aborted and no register is updated.
- After release, the first complete setup+access pair behaves normally.

Write latency:
- The register updates on the access-phase edge.
- oGPIO_OUT and oGPIO_OE change on that same edge.

Input latency, with E0 the first edge that samples the new pin level:
- DIN reflects it after E1.
- EDGE bit sets after E2.
- oIRQ asserts after E2 if enabled.

Blink timing:
- With PERIOD = P > 0, phase toggles every P+1 cycles.
- Full blink period is 2(P+1) cycles.

Back-to-back transfers:
- Supports back-to-back transfers in the form setup, access, setup, access, with no idle cycle between them.
- A read immediately following a write to the same register returns the new value (the write edge precedes the read setup edge).

## Test plan
- Reset check: hold iHRESETn low mid-transfer -> all outputs 0; after release, read 0x10 returns 0 and phase = 1.
- Write/read: write DOUT = 0xA5A5, DIR = 0x00FF, then read both back -> oPRDATA = 0x0000A5A5 and 0x000000FF in the respective access phases; oGPIO_OUT = 0xA5A5 and oGPIO_OE = 0x00FF from the write edges.
- Edge and IRQ: set IRQ_EN = 0x0001 and raise iGPIO_IN[0] -> DIN[0] = 1 after E1, EDGE = 0x0001 and oIRQ = 1 after E2. Write 0x14 with 0x0001 -> EDGE = 0 and oIRQ = 0. Then clear in the same cycle as a new rise on bit 0 -> the bit stays 1.
- Blink: DOUT = 0x0003, BLINK_EN = 0x0001, PERIOD = 3 -> bit0 is 0 for 4 cycles then 1 for 4 cycles, repeating; bit1 is constantly 1. Write PERIOD = 0 -> bit0 is steady at 1.
- Decode boundaries: read 0x1C and 0x08-with-write -> read returns 0; DIN is unchanged. iPADDR = 0x8004 aliases DIR.
